mem_readback: RTL and testbench

MEM_READBACK -- requirements
Module: mem_readback

---
 rtl/mem_readback.sv | 127 ++++++++++++
 tb/tb_mem_readback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readback.sv
// Sweeps a synchronous-read memory from address 0 to DEPTH_MEM-1 and streams
// each word with its address through a 4-entry valid/ready output FIFO.
module mem_readback #(
    parameter int WID_MEM   = 256,
    parameter int DEPTH_MEM = 256,
    parameter int ADDR_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WID_MEM-1:0] m_data,
    output logic [ADDR_W-1:0]  m_addr,
    output logic               m_last
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic               flightValid_q;
    logic [ADDR_W-1:0]  flightAddr_q;
    logic [WID_MEM-1:0] fifoData_q [4];
    logic [ADDR_W-1:0]  fifoAddr_q [4];
    logic [1:0]         wrPtr_q;
    logic [1:0]         rdPtr_q;
    logic [2:0]         count_q;
    logic [2:0]         count_d;
    logic               done_q;
    logic               issue;
    logic               push;
    logic               pop;

    assign m_valid = (count_q != 3'd0);
    assign m_data  = fifoData_q[rdPtr_q];
    assign m_addr  = fifoAddr_q[rdPtr_q];
    assign m_last  = m_valid && (m_addr == LAST_ADDR);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign raddr   = raddr_q;
    assign push    = flightValid_q;
    assign pop     = m_valid && m_ready;
    assign count_d = count_q + {2'b00, push} - {2'b00, pop};

    // Reads are throttled so buffered plus in-flight words never exceed the
    // FIFO depth; a start coinciding with the done pulse is not accepted.
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d = RUN;
                    raddr_d = '0;
                end
            end
            RUN: begin
                if ((count_q + {2'b00, flightValid_q}) < 3'd4) begin
                    issue = 1'b1;
                    if (raddr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        raddr_d = raddr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            raddr_q       <= '0;
            flightValid_q <= 1'b0;
            flightAddr_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            raddr_q       <= raddr_d;
            flightValid_q <= issue;
            flightAddr_q  <= raddr_q;
            done_q        <= pop && m_last;
        end
    end

    // Memory data for last cycle's read is present now and captured here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifoData_q[i] <= '0;
                fifoAddr_q[i] <= '0;
            end
            wrPtr_q <= 2'd0;
            rdPtr_q <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (push) begin
                fifoData_q[wrPtr_q] <= rdata;
                fifoAddr_q[wrPtr_q] <= flightAddr_q;
                wrPtr_q             <= wrPtr_q + 2'd1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback: full sweeps, stalls, ignored starts,
// mid-sweep reset and a single-word configuration.
module tb_mem_readback;

    localparam int WID   = 256;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           busy;
    logic           done;
    logic [AW-1:0]  raddr;
    logic [WID-1:0] rdata;
    logic           m_valid;
    logic           m_ready;
    logic [WID-1:0] m_data;
    logic [AW-1:0]  m_addr;
    logic           m_last;

    logic           startS;
    logic           busyS;
    logic           doneS;
    logic [AW-1:0]  raddrS;
    logic [WID-1:0] rdataS;
    logic           m_validS;
    logic           m_readyS;
    logic [WID-1:0] m_dataS;
    logic [AW-1:0]  m_addrS;
    logic           m_lastS;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Memory preloaded with word[i] = i, one-edge read latency.
    always @(posedge clk) begin
        rdata  <= WID'(raddr);
        rdataS <= WID'(raddrS);
    end

    mem_readback #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .raddr(raddr), .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_addr(m_addr), .m_last(m_last)
    );

    mem_readback #(.WID_MEM(WID), .DEPTH_MEM(1), .ADDR_W(AW)) dutSingle (
        .clk(clk), .reset(reset), .start(startS), .busy(busyS), .done(doneS),
        .raddr(raddrS), .rdata(rdataS), .m_valid(m_validS), .m_ready(m_readyS),
        .m_data(m_dataS), .m_addr(m_addrS), .m_last(m_lastS)
    );

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after applyStimulus with m_ready held high.
    task automatic sweepStreaming(input string tag);
        checkOutput({tag, " busy after start"}, busy, 1'b1);
        checkOutput({tag, " raddr after start"}, raddr, 0);
        checkOutput({tag, " valid edge1"}, m_valid, 1'b0);
        @(negedge clk);
        checkOutput({tag, " valid edge2"}, m_valid, 1'b0);
        checkOutput({tag, " raddr edge2"}, raddr, 1);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("%s valid %0d", tag, i), m_valid, 1'b1);
            checkOutput($sformatf("%s addr %0d", tag, i), m_addr, i);
            checkOutput($sformatf("%s data %0d", tag, i), m_data, i);
            checkOutput($sformatf("%s last %0d", tag, i), m_last, (i == DEPTH - 1));
            @(negedge clk);
        end
        checkOutput({tag, " done pulse"}, done, 1'b1);
        checkOutput({tag, " busy fell"}, busy, 1'b0);
        checkOutput({tag, " valid empty"}, m_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int readyPattern [4];
        int expAddr;
        int phase;
        logic prevStall;
        logic [AW-1:0] prevAddr;
        logic [WID-1:0] prevData;
        logic startPulsed;

        readyPattern = '{1, 0, 0, 1};
        reset    = 1'b1;
        start    = 1'b0;
        startS   = 1'b0;
        m_ready  = 1'b1;
        m_readyS = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset valid", m_valid, 1'b0);
        checkOutput("reset last", m_last, 1'b0);
        checkOutput("reset raddr", raddr, 0);
        checkOutput("reset m_addr", m_addr, 0);
        checkOutput("reset m_data", m_data, 0);
        reset = 1'b0;

        $display("[TB] streaming sweep with m_ready high");
        applyStimulus();
        sweepStreaming("A");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("A start on done ignored", busy, 1'b0);
        checkOutput("A raddr holds last", raddr, DEPTH - 1);
        checkOutput("A done single", done, 1'b0);

        $display("[TB] backpressure sweep");
        m_ready = 1'b0;
        applyStimulus();
        repeat (20) @(negedge clk);
        checkOutput("B stall raddr", raddr, 4);
        checkOutput("B stall valid", m_valid, 1'b1);
        checkOutput("B stall addr", m_addr, 0);
        checkOutput("B stall data", m_data, 0);
        expAddr     = 0;
        phase       = 0;
        prevStall   = 1'b0;
        prevAddr    = '0;
        prevData    = '0;
        startPulsed = 1'b0;
        for (int cyc = 0; cyc < 2000 && expAddr < DEPTH; cyc++) begin
            if (prevStall) begin
                checkOutput($sformatf("B hold valid %0d", cyc), m_valid, 1'b1);
                checkOutput($sformatf("B hold addr %0d", cyc), m_addr, prevAddr);
                checkOutput($sformatf("B hold data %0d", cyc), m_data, prevData);
            end
            checkOutput($sformatf("B outstanding %0d", cyc), (int'(raddr) - expAddr) <= 4, 1'b1);
            start = 1'b0;
            if (expAddr == 100 && !startPulsed) begin
                start       = 1'b1;
                startPulsed = 1'b1;
            end
            m_ready = (readyPattern[phase % 4] != 0);
            phase++;
            if (m_valid && m_ready) begin
                checkOutput($sformatf("B addr %0d", expAddr), m_addr, expAddr);
                checkOutput($sformatf("B data %0d", expAddr), m_data, expAddr);
                checkOutput($sformatf("B last %0d", expAddr), m_last, (expAddr == DEPTH - 1));
                expAddr++;
            end
            prevStall = m_valid && !m_ready;
            prevAddr  = m_addr;
            prevData  = m_data;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("B word count", expAddr, DEPTH);
        checkOutput("B done pulse", done, 1'b1);
        checkOutput("B busy fell", busy, 1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("B no second done %0d", i), done, 1'b0);
            checkOutput($sformatf("B stays idle %0d", i), busy, 1'b0);
        end

        $display("[TB] reset mid-sweep");
        applyStimulus();
        repeat (2) @(negedge clk);
        repeat (50) @(negedge clk);
        checkOutput("C at word 50", m_addr, 50);
        #2 reset = 1'b1;
        #1;
        checkOutput("C async valid", m_valid, 1'b0);
        checkOutput("C async busy", busy, 1'b0);
        checkOutput("C async raddr", raddr, 0);
        checkOutput("C async m_addr", m_addr, 0);
        checkOutput("C async m_data", m_data, 0);
        checkOutput("C async last", m_last, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("C quiet valid %0d", i), m_valid, 1'b0);
            checkOutput($sformatf("C quiet busy %0d", i), busy, 1'b0);
        end
        applyStimulus();
        sweepStreaming("C");

        $display("[TB] single-word configuration");
        @(negedge clk);
        startS = 1'b1;
        @(negedge clk);
        startS = 1'b0;
        checkOutput("D busy", busyS, 1'b1);
        checkOutput("D valid edge1", m_validS, 1'b0);
        @(negedge clk);
        checkOutput("D valid edge2", m_validS, 1'b0);
        checkOutput("D raddr holds", raddrS, 0);
        @(negedge clk);
        checkOutput("D valid", m_validS, 1'b1);
        checkOutput("D last", m_lastS, 1'b1);
        checkOutput("D addr", m_addrS, 0);
        checkOutput("D done early", doneS, 1'b0);
        @(negedge clk);
        checkOutput("D done pulse", doneS, 1'b1);
        checkOutput("D busy fell", busyS, 1'b0);
        checkOutput("D valid empty", m_validS, 1'b0);
        @(negedge clk);
        checkOutput("D done one cycle", doneS, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
